// File: rtl/matrix_pkg.sv
// Shared types for the 16x16 bicolour LED matrix scanner: plane layout and scan FSM states.
package matrix_pkg;
    localparam int MATRIX_N = 16;

    typedef logic [MATRIX_N-1:0][MATRIX_N-1:0] plane_t;
    typedef enum logic [1:0] {SNAP, BLANK, DRIVE} scan_state_t;

    function automatic logic [MATRIX_N-1:0] row_sel_n(input logic [3:0] row);
        return ~(16'h1 << row);
    endfunction
endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter shared by the BLANK and DRIVE phases of the matrix scanner.
module scan_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         done
);
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    // A phase loaded with N lasts N cycles; done marks the final one.
    assign done = (cnt == W'(1));
endmodule

// File: rtl/led_matrix_scanner.sv
// Row-scanned driver for a 16x16 bicolour LED matrix with per-frame snapshot of both planes.
// Optional LED_MATRIX_DIM_EN adds a 3-bit brightness input that limits column duty within DRIVE.
module led_matrix_scanner
    import matrix_pkg::*;
#(
    parameter int DWELL_CYCLES = 4096,
    parameter int BLANK_CYCLES = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [MATRIX_N-1:0][MATRIX_N-1:0] RedPixels,
    input  logic [MATRIX_N-1:0][MATRIX_N-1:0] GrnPixels,
`ifdef LED_MATRIX_DIM_EN
    input  logic [2:0]                       brightness,
`endif
    output logic [MATRIX_N-1:0]              row_n,
    output logic [MATRIX_N-1:0]              red_col,
    output logic [MATRIX_N-1:0]              grn_col,
    output logic                             frame_done
);
    localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int PW   = $clog2(MAXC + 1);

    scan_state_t   state;
    logic [3:0]    row;
    plane_t        shadow_red;
    plane_t        shadow_grn;
    logic [PW-1:0] cnt;
    logic          tdone;
    logic          tload;
    logic [PW-1:0] tval;
    logic [PW-1:0] nxt_phase;
    logic [2:0]    bright;

    function automatic logic duty_on(input logic [PW-1:0] phase, input logic [2:0] b);
        logic [31:0] lim;
        lim = ((32'(b) + 32'd1) * 32'(DWELL_CYCLES)) >> 3;
        return 32'(phase) < lim;
    endfunction

    assign tload = (state == SNAP) || tdone;
    assign tval  = (state == BLANK) ? PW'(DWELL_CYCLES) : PW'(BLANK_CYCLES);
    // Phase index of the DRIVE cycle that follows the current one.
    assign nxt_phase = PW'(DWELL_CYCLES) - cnt + PW'(1);

    scan_timer #(.W(PW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tload),
        .load_val (tval),
        .cnt      (cnt),
        .done     (tdone)
    );

`ifdef LED_MATRIX_DIM_EN
    always_ff @(posedge clk) begin
        if (reset)
            bright <= 3'd7;
        else if (state == SNAP)
            bright <= brightness;
    end
`else
    assign bright = 3'd7;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SNAP;
            row        <= '0;
            row_n      <= '1;
            red_col    <= '0;
            grn_col    <= '0;
            frame_done <= 1'b0;
            shadow_red <= '0;
            shadow_grn <= '0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                SNAP: begin
                    shadow_red <= RedPixels;
                    shadow_grn <= GrnPixels;
                    row        <= '0;
                    state      <= BLANK;
                end
                BLANK: begin
                    if (tdone) begin
                        state   <= DRIVE;
                        row_n   <= row_sel_n(row);
                        red_col <= duty_on(PW'(0), bright) ? shadow_red[row] : '0;
                        grn_col <= duty_on(PW'(0), bright) ? shadow_grn[row] : '0;
                    end
                end
                DRIVE: begin
                    if (tdone) begin
                        row_n   <= '1;
                        red_col <= '0;
                        grn_col <= '0;
                        if (row == 4'd15) begin
                            state      <= SNAP;
                            frame_done <= 1'b1;
                        end else begin
                            row   <= row + 1'b1;
                            state <= BLANK;
                        end
                    end else begin
                        red_col <= duty_on(nxt_phase, bright) ? shadow_red[row] : '0;
                        grn_col <= duty_on(nxt_phase, bright) ? shadow_grn[row] : '0;
                    end
                end
                default: state <= SNAP;
            endcase
        end
    end
endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner: per-cycle frame-level reference model plus scenario checks.
module tb_led_matrix_scanner;
    import matrix_pkg::*;

`ifdef LED_MATRIX_DIM_EN
    localparam int D = 8;
`else
    localparam int D = 4;
`endif
    localparam int B = 2;
    localparam int F = 1 + 16 * (B + D);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    plane_t      red_in = '0;
    plane_t      grn_in = '0;
    logic [2:0]  bright_in = 3'd7;
    logic [15:0] row_n, red_col, grn_col;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    int          t = 0;
    bit          first = 1'b1;
    plane_t      snap_r = '0;
    plane_t      snap_g = '0;
    logic [2:0]  snap_b = 3'd7;
    logic [15:0] e_row_n, e_red, e_grn;
    logic        e_fd;

    always #5 clk = ~clk;

    led_matrix_scanner #(.DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
        .clk        (clk),
        .reset      (reset),
        .RedPixels  (red_in),
        .GrnPixels  (grn_in),
`ifdef LED_MATRIX_DIM_EN
        .brightness (bright_in),
`endif
        .row_n      (row_n),
        .red_col    (red_col),
        .grn_col    (grn_col),
        .frame_done (frame_done)
    );

    function automatic plane_t rand_plane();
        plane_t p;
        for (int i = 0; i < 16; i++) p[i] = 16'($urandom());
        return p;
    endfunction

    // Expected outputs from the position t within the frame (t=0 is the SNAP cycle).
    task automatic model();
        int r, p, lim;
        e_row_n = '1; e_red = '0; e_grn = '0; e_fd = 1'b0;
        if (t == 0) begin
            e_fd = !first;
        end else begin
            r = (t - 1) / (B + D);
            p = (t - 1) % (B + D);
            if (p >= B) begin
                e_row_n = ~(16'h1 << r);
                lim = ((int'(snap_b) + 1) * D) >> 3;
                if (p - B < lim) begin
                    e_red = snap_r[r];
                    e_grn = snap_g[r];
                end
            end
        end
    endtask

    task automatic tick();
        bit rs;
        if (t == 0 && !reset) begin
            snap_r = red_in; snap_g = grn_in; snap_b = bright_in;
        end
        rs = reset;
        @(posedge clk); #1;
        if (rs) begin
            t = 0; first = 1'b1;
        end else if (t == F - 1) begin
            t = 0; first = 1'b0;
        end else begin
            t++;
        end
        model();
    endtask

    task automatic sync();
        for (int i = 0; i < F && t != 0; i++) tick();
    endtask

    task automatic test_reset();
        int n, first_fe;
        int fd_at[$];
        reset = 1'b1; red_in = rand_plane(); grn_in = rand_plane();
        repeat (3) begin
            tick();
            checks++;
            if ({row_n, red_col, grn_col, frame_done} !== {16'hFFFF, 16'h0, 16'h0, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold got %h %h %h %b exp ffff 0000 0000 0", row_n, red_col, grn_col, frame_done);
            end
        end
        reset = 1'b0;
        n = 0; first_fe = -1;
        for (int i = 0; i < 2 * F + 2; i++) begin
            tick(); n++;
            checks++;
            if ({row_n, red_col, grn_col, frame_done} !== {e_row_n, e_red, e_grn, e_fd}) begin
                errors++;
                $display("FAIL reset_scan t=%0d got %h %h %h %b exp %h %h %h %b", t, row_n, red_col, grn_col, frame_done, e_row_n, e_red, e_grn, e_fd);
            end
            if (first_fe < 0 && row_n == 16'hFFFE) first_fe = n;
            if (frame_done === 1'b1) fd_at.push_back(n);
        end
        checks++;
        if (first_fe != 3) begin
            errors++;
            $display("FAIL first_row_latency got %0d exp 3", first_fe);
        end
        checks++;
        if (fd_at.size() != 2 || fd_at[0] != F || fd_at[1] != 2 * F) begin
            errors++;
            $display("FAIL frame_done_period got count %0d first %0d exp count 2 at %0d and %0d", fd_at.size(), (fd_at.size() > 0) ? fd_at[0] : -1, F, 2 * F);
        end
    endtask

    task automatic test_single_pixel();
        int hits, stray;
        sync();
        red_in = '0; grn_in = '0; red_in[13] = 16'h0100;
        hits = 0; stray = 0;
        repeat (F) begin
            tick();
            checks++;
            if ({row_n, red_col, grn_col, frame_done} !== {e_row_n, e_red, e_grn, e_fd}) begin
                errors++;
                $display("FAIL single_pixel t=%0d got %h %h %h %b exp %h %h %h %b", t, row_n, red_col, grn_col, frame_done, e_row_n, e_red, e_grn, e_fd);
            end
            if (row_n == 16'hDFFF && red_col == 16'h0100 && grn_col == 16'h0) hits++;
            else if (red_col != 16'h0 || grn_col != 16'h0) stray++;
        end
        checks++;
        if (hits != D || stray != 0) begin
            errors++;
            $display("FAIL single_pixel_count got hits %0d stray %0d exp hits %0d stray 0", hits, stray, D);
        end
    endtask

    task automatic test_tear_free();
        int torn, shown;
        sync();
        red_in = rand_plane(); grn_in = '0;
        for (int i = 0; i < 1 + 5 * (B + D) + B; i++) tick();
        for (int i = 0; i < 16; i++) grn_in[i] = 16'hFFFF;
        torn = 0;
        while (t != 0) begin
            tick();
            checks++;
            if ({row_n, red_col, grn_col, frame_done} !== {e_row_n, e_red, e_grn, e_fd}) begin
                errors++;
                $display("FAIL tear_cur t=%0d got %h %h %h %b exp %h %h %h %b", t, row_n, red_col, grn_col, frame_done, e_row_n, e_red, e_grn, e_fd);
            end
            if (grn_col != 16'h0) torn++;
        end
        shown = 0;
        repeat (F) begin
            tick();
            checks++;
            if ({row_n, red_col, grn_col, frame_done} !== {e_row_n, e_red, e_grn, e_fd}) begin
                errors++;
                $display("FAIL tear_next t=%0d got %h %h %h %b exp %h %h %h %b", t, row_n, red_col, grn_col, frame_done, e_row_n, e_red, e_grn, e_fd);
            end
            if (row_n == 16'hFFFE && grn_col == 16'hFFFF) shown++;
        end
        checks++;
        if (torn != 0 || shown != D) begin
            errors++;
            $display("FAIL tear_free got torn %0d shown %0d exp torn 0 shown %0d", torn, shown, D);
        end
    endtask

    task automatic test_amber();
        int seen;
        sync();
        red_in = '0; grn_in = '0; red_in[2][3] = 1'b1; grn_in[2][3] = 1'b1;
        seen = 0;
        repeat (F) begin
            tick();
            if (row_n == 16'hFFFB) begin
                seen++;
                checks++;
                if (red_col !== 16'h0008 || grn_col !== 16'h0008) begin
                    errors++;
                    $display("FAIL amber got red %h grn %h exp 0008 0008", red_col, grn_col);
                end
            end
        end
        checks++;
        if (seen != D) begin
            errors++;
            $display("FAIL amber_rows got %0d exp %0d", seen, D);
        end
    endtask

    task automatic test_reset_midframe();
        int n, first_fe;
        sync();
        red_in = rand_plane(); grn_in = rand_plane();
        for (int i = 0; i < 1 + 9 * (B + D) + B + 1; i++) tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({row_n, red_col, grn_col, frame_done} !== {16'hFFFF, 16'h0, 16'h0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset got %h %h %h %b exp ffff 0000 0000 0", row_n, red_col, grn_col, frame_done);
        end
        reset = 1'b0;
        n = 0; first_fe = -1;
        repeat (F + 1) begin
            tick(); n++;
            checks++;
            if ({row_n, red_col, grn_col, frame_done} !== {e_row_n, e_red, e_grn, e_fd}) begin
                errors++;
                $display("FAIL mid_reset_scan t=%0d got %h %h %h %b exp %h %h %h %b", t, row_n, red_col, grn_col, frame_done, e_row_n, e_red, e_grn, e_fd);
            end
            if (first_fe < 0 && row_n == 16'hFFFE) first_fe = n;
        end
        checks++;
        if (first_fe != 3) begin
            errors++;
            $display("FAIL mid_reset_restart got %0d exp 3", first_fe);
        end
    endtask

`ifdef LED_MATRIX_DIM_EN
    task automatic test_dim();
        int lit, sel;
        sync();
        red_in = '1; grn_in = '0;
        for (int pass = 0; pass < 2; pass++) begin
            bright_in = (pass == 0) ? 3'd3 : 3'd7;
            lit = 0; sel = 0;
            repeat (F) begin
                tick();
                checks++;
                if ({row_n, red_col, grn_col, frame_done} !== {e_row_n, e_red, e_grn, e_fd}) begin
                    errors++;
                    $display("FAIL dim t=%0d got %h %h %h %b exp %h %h %h %b", t, row_n, red_col, grn_col, frame_done, e_row_n, e_red, e_grn, e_fd);
                end
                if (row_n != 16'hFFFF) sel++;
                if (row_n != 16'hFFFF && red_col != 16'h0) lit++;
            end
            checks++;
            if (sel != 16 * D || lit != ((pass == 0) ? 16 * 4 : 16 * 8)) begin
                errors++;
                $display("FAIL dim_duty b=%0d got lit %0d sel %0d exp lit %0d sel %0d", bright_in, lit, sel, (pass == 0) ? 64 : 128, 16 * D);
            end
        end
    endtask
`endif

    task automatic test_random();
        red_in = rand_plane(); grn_in = rand_plane();
        repeat (6 * F) begin
            if ($urandom_range(0, 9) == 0) red_in[$urandom_range(0, 15)] = 16'($urandom());
            if ($urandom_range(0, 9) == 0) grn_in[$urandom_range(0, 15)] = 16'($urandom());
            if ($urandom_range(0, 99) == 0) begin
                red_in = rand_plane(); grn_in = rand_plane();
            end
`ifdef LED_MATRIX_DIM_EN
            if ($urandom_range(0, 19) == 0) bright_in = 3'($urandom_range(0, 7));
`endif
            tick();
            checks++;
            if ({row_n, red_col, grn_col, frame_done} !== {e_row_n, e_red, e_grn, e_fd}) begin
                errors++;
                $display("FAIL random t=%0d got %h %h %h %b exp %h %h %h %b", t, row_n, red_col, grn_col, frame_done, e_row_n, e_red, e_grn, e_fd);
            end
        end
        bright_in = 3'd7;
    endtask

    initial begin
        model();
        test_reset();
        test_single_pixel();
        test_tear_free();
        test_amber();
`ifdef LED_MATRIX_DIM_EN
        test_dim();
`endif
        test_random();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
